instr_prefetch_queue: RTL
=========================

Name: instr_prefetch_queue

Overview:
- Fetch front end placed between the instruction memory port and the IF/ID pipeline register.
- Issues sequential word fetches to a memory with variable latency. Buffers the returned instructions, each paired with its PC+4, in a DEPTH-entry FIFO.
- Hands entries to IF/ID under a valid/ready stall handshake.
- A branch taken at the MEM stage causes a redirect: the queue is flushed and fetch restarts at the branch target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_i  in  1  taken-branch flush (PCSrc from the MEM stage).
- redirect_pc_i  in  32  branch target.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  32  fetch address; word aligned.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  response valid; responses return in order.
- mem_rdata_i  in  32  instruction word.
- valid_o  out  1  instr_o and pc_plus4_o are valid.
- ready_i  in  1  IF/ID can accept this cycle; low means stall.
- instr_o  out  32  instruction at the FIFO head.
- pc_plus4_o  out  32  address of the head instruction plus 4.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; count=0; state=IDLE.
  - Outputs: mem_req_o=0, valid_o=0, instr_o=0, pc_plus4_o=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request granted, awaiting rvalid.
  - DROP: one request granted but stale; its response is discarded.
- Request rule:
  - mem_req_o = (state==IDLE) && (count<DEPTH) && !redirect_i.
  - mem_req_o is combinational; mem_addr_o = fetch_pc.
  - Request and address are held stable until mem_gnt_i.
- Grant: on req&&gnt, fetch_pc += 4 (wraps modulo 2^32) and IDLE->WAIT.
- Response in WAIT with rvalid and no redirect:
  - Push {mem_rdata_i, address+4} into the FIFO; WAIT->IDLE.
  - The slot was reserved at request time, so a push never overflows.
- Outstanding limit: at most one request in flight. A new request may be issued the cycle after the response (IDLE).
- Pop: on valid_o&&ready_i the head is removed.
  - Push and pop in the same cycle leaves count unchanged. This is legal at full and at empty.
- Output register: valid_o = (count!=0); instr_o and pc_plus4_o show the FIFO head.
  - Head contents hold while ready_i=0 (stall); no entry is lost or duplicated.
  - When empty, instr_o and pc_plus4_o hold their last value.
- Latency (feature off): rvalid in cycle N gives valid_o in cycle N+1.
- Redirect (highest priority):
  - FIFO cleared; count=0.
  - fetch_pc={redirect_pc_i[31:2],2'b00}; the low two bits are forced to zero.
  - valid_o=0 from the next cycle.
  - An entry at the head during the redirect cycle is not popped, even if ready_i=1. valid_o is masked to 0 in that cycle.
  - State transitions on redirect:
    - IDLE: stays IDLE.
    - WAIT without rvalid: goes to DROP.
    - WAIT with rvalid the same cycle: the response is discarded; goes to IDLE.
    - DROP: stays DROP.
- DROP state:
  - mem_req_o=0.
  - On rvalid, discard the data and go to IDLE; the next cycle requests fetch_pc.
- Unexpected rvalid in IDLE is ignored.
- Reset asserted mid-transaction returns to IDLE immediately. Any later stray rvalid is ignored per the IDLE rule.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - If the FIFO is empty, state is WAIT, mem_rvalid_i=1, ready_i=1 and redirect_i=0, then mem_rdata_i is forwarded combinationally to instr_o/pc_plus4_o with valid_o=1 in the same cycle. The word is not pushed.
  - If ready_i=0 in that case, it is pushed as normal.
  - Zero-cycle latency.
- Undefined: all data passes through the FIFO with 1-cycle latency as above.

Test Plan:
- Reset, then release with mem_gnt_i=1 and a 1-cycle memory returning 32'hA000_0000+addr; ready_i=1 -> mem_addr_o sequence 0,4,8,...; valid_o first high 1 cycle after the first rvalid; pc_plus4_o=4,8,12; in-order instructions.
- Hold ready_i=0 with DEPTH=4 -> exactly 4 entries accepted; mem_req_o=0 while count=4; head stays instr@0. Release ready_i -> 4 pops, then fetch resumes at 16.
- redirect_i=1 with redirect_pc_i=32'h0000_0103 while in WAIT, rvalid 3 cycles later -> FIFO empty; that response dropped; next mem_addr_o=32'h0000_0100; first delivered pc_plus4_o=32'h104.
- redirect_i together with mem_rvalid_i in WAIT, target 32'h40 -> word discarded; state IDLE; next request addr 32'h40; valid_o=0 the cycle after.
- Simultaneous push and pop at count=DEPTH-1 and at count=1 -> count unchanged; order preserved; no overflow or underflow.
- rst_n pulsed low mid-WAIT, then stray rvalid -> all outputs 0; rvalid ignored; fetch restarts at RESET_PC. With PREFETCH_BYPASS_EN: empty FIFO and rvalid&&ready_i -> valid_o high in the same cycle.

Source files
------------

// File: rtl/instr_prefetch_queue_if.sv
// Handshake bundle for the instruction prefetch queue: memory fetch port,
// IF/ID delivery port and the branch redirect from the MEM stage.
// master = the prefetch queue itself, slave = memory / pipeline side.
interface instr_prefetch_queue_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;

    modport master (
        input  redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
        output mem_req_o, mem_addr_o, valid_o, instr_o, pc_plus4_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
        input  mem_req_o, mem_addr_o, valid_o, instr_o, pc_plus4_o
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches (one in flight),
// buffers {instr, pc+4} in a DEPTH-entry FIFO and hands them to IF/ID under a
// valid/ready stall handshake. A redirect flushes the queue and restarts
// fetch at the branch target; a response still in flight is dropped.
// Optional macro PREFETCH_BYPASS_EN: forward a response straight to the
// outputs when the FIFO is empty and IF/ID is ready (zero-cycle latency).
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    instr_prefetch_queue_if.master bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];
    logic [31:0]   last_instr_reg, last_pc4_reg;
    logic          grant, rsp, push, pop, bypass, fifo_nonempty;

    assign fifo_nonempty = (count_reg != '0);

    // A slot is reserved at request time, so only request while not full.
    assign bus.mem_req_o  = rst_n && (state_reg == ST_IDLE) && (count_reg < FULL_CNT)
                            && !bus.redirect_i;
    assign bus.mem_addr_o = fetch_pc_reg;
    assign grant          = bus.mem_req_o && bus.mem_gnt_i;
    assign rsp            = (state_reg == ST_WAIT) && bus.mem_rvalid_i && !bus.redirect_i;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = rsp && !fifo_nonempty && bus.ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push        = rsp && !bypass;
    // The head is never consumed in a redirect cycle.
    assign pop         = fifo_nonempty && bus.ready_i && !bus.redirect_i;
    assign bus.valid_o = (fifo_nonempty && !bus.redirect_i) || bypass;

    // Output mux: forwarded word, FIFO head, or last shown value when empty.
    always_comb begin
        bus.instr_o    = last_instr_reg;
        bus.pc_plus4_o = last_pc4_reg;
        if (bypass) begin
            bus.instr_o    = bus.mem_rdata_i;
            bus.pc_plus4_o = fetch_pc_reg;
        end else if (fifo_nonempty) begin
            bus.instr_o    = instr_mem[rd_ptr_reg];
            bus.pc_plus4_o = pc4_mem[rd_ptr_reg];
        end
    end

    // Next-state and fetch address; redirect takes precedence over grant.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        case (state_reg)
            ST_IDLE: if (grant) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.mem_rvalid_i)     state_next = ST_IDLE;
                else if (bus.redirect_i)  state_next = ST_DROP;
            end
            ST_DROP: if (bus.mem_rvalid_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (bus.redirect_i)
            fetch_pc_next = bus.redirect_pc_i & 32'hFFFF_FFFC;
        else if (grant)
            fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    // Occupancy: flush on redirect, otherwise track push/pop.
    always_comb begin
        count_next = count_reg;
        if (bus.redirect_i)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    // Control state, pointers and last-shown output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            fetch_pc_reg   <= RESET_PC;
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            last_instr_reg <= '0;
            last_pc4_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            count_reg      <= count_next;
            last_instr_reg <= bus.instr_o;
            last_pc4_reg   <= bus.pc_plus4_o;
            if (bus.redirect_i) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // FIFO storage; fetch_pc already holds the granted address plus 4.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= bus.mem_rdata_i;
            pc4_mem[wr_ptr_reg]   <= fetch_pc_reg;
        end
    end
endmodule
